scan_chain_ctrl: RTL and testbench

Parametrised multi-chain scan controller that shifts NUM_CHAINS scan chains in parallel. Shift-in data is unpacked from DATA_WIDTH-bit words taken from an input FIFO. Captured scan-out bits are repacked into words and pushed to an output FIFO. It sits between the AXI DMA master's FIFO pair and the design-under-snapshot, replacing the single-chain shifter, and adds a programmable shift-clock divider, abort and functional capture.

---
 rtl/scan_chain_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Multi-chain scan controller: unpacks FIFO words onto NUM_CHAINS chain heads, repacks tails into words.
// Optional functional-capture cycle before shifting is enabled by defining SCAN_CAPTURE_EN.
module scan_chain_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CHAINS = 4,
  parameter int LEN_WIDTH  = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic                  capture,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr_en,
  input  logic                  out_almost_full,
  input  logic [NUM_CHAINS-1:0] scan_output,
  output logic [NUM_CHAINS-1:0] scan_input,
  output logic                  scan_enable,
  output logic                  scan_ck_enable
);
  localparam int S     = DATA_WIDTH / NUM_CHAINS;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(S - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_WRITE,
`ifdef SCAN_CAPTURE_EN
    ST_CAPTURE,
`endif
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic [LEN_WIDTH:0]    r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_in_word;
  logic [DATA_WIDTH-1:0] r_out_word;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [NUM_CHAINS-1:0] r_scan_in;
  logic r_busy, r_done, r_rd_en, r_wr_en, r_scan_en, r_ck_en;

  logic [LEN_WIDTH:0]    w_cnt_inc;
  logic                  w_last_bit;
  logic                  w_cnt_done;
  logic [DIV_WIDTH-1:0]  w_div_inc;
  logic [DATA_WIDTH-1:0] w_out_next;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last_bit = (w_cnt_inc == {1'b0, r_len});
  assign w_cnt_done = (r_cnt == {1'b0, r_len});
  assign w_div_inc  = r_div_cnt + 1'b1;

  // Tail bits land in the current shift slot; the pulse edge is when they are captured.
  always_comb begin
    w_out_next = r_out_word;
    w_out_next[int'(r_idx) * NUM_CHAINS +: NUM_CHAINS] = scan_output;
  end

`ifndef SCAN_CAPTURE_EN
  logic w_unused_capture;
  assign w_unused_capture = capture;
`endif

  // Strobes are registered one cycle ahead: FIFO empty/full flags are sampled on the edge
  // that enters LOAD/WRITE so the pop/push lands in the very next cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_div      <= '0;
      r_div_cnt  <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_in_word  <= '0;
      r_out_word <= '0;
      r_out_data <= '0;
      r_scan_in  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_scan_en  <= 1'b0;
      r_ck_en    <= 1'b0;
    end else if (abort && r_state != ST_IDLE) begin
      r_state    <= ST_IDLE;
      r_out_data <= '0;
      r_scan_in  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_scan_en  <= 1'b0;
      r_ck_en    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len  <= length;
            r_div  <= div;
            r_cnt  <= '0;
            r_busy <= 1'b1;
`ifdef SCAN_CAPTURE_EN
            if (capture) begin
              r_state <= ST_CAPTURE;
              r_ck_en <= 1'b1;
            end else
`endif
            if (length == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state   <= ST_LOAD;
              r_scan_en <= 1'b1;
              r_rd_en   <= !in_empty;
            end
          end
        end
`ifdef SCAN_CAPTURE_EN
        ST_CAPTURE: begin
          r_ck_en <= 1'b0;
          if (r_len == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_LOAD;
            r_scan_en <= 1'b1;
            r_rd_en   <= !in_empty;
          end
        end
`endif
        ST_LOAD: begin
          if (r_rd_en) begin
            r_rd_en    <= 1'b0;
            r_scan_in  <= in_data[NUM_CHAINS-1:0];
            r_in_word  <= in_data >> NUM_CHAINS;
            r_out_word <= '0;
            r_idx      <= '0;
            r_div_cnt  <= '0;
            r_ck_en    <= (r_div == '0);
            r_state    <= ST_SHIFT;
          end else if (!in_empty) begin
            r_rd_en <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_ck_en) begin
            r_out_word <= w_out_next;
            r_cnt      <= w_cnt_inc;
            if (r_idx == LAST_IDX || w_last_bit) begin
              r_state    <= ST_WRITE;
              r_ck_en    <= 1'b0;
              r_out_data <= w_out_next;
              r_wr_en    <= !out_almost_full;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_scan_in <= r_in_word[NUM_CHAINS-1:0];
              r_in_word <= r_in_word >> NUM_CHAINS;
              r_div_cnt <= '0;
              r_ck_en   <= (r_div == '0);
            end
          end else begin
            r_div_cnt <= w_div_inc;
            r_ck_en   <= (w_div_inc == r_div);
          end
        end
        ST_WRITE: begin
          if (r_wr_en) begin
            r_wr_en <= 1'b0;
            if (w_cnt_done) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_scan_en <= 1'b0;
            end else begin
              r_state <= ST_LOAD;
              r_rd_en <= !in_empty;
            end
          end else if (!out_almost_full) begin
            r_wr_en <= 1'b1;
          end
        end
        ST_DONE: begin
          // Zero-length jobs arrive with done still low and raise it here.
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign in_rd_en       = r_rd_en;
  assign out_data       = r_out_data;
  assign out_wr_en      = r_wr_en;
  assign scan_input     = r_scan_in;
  assign scan_enable    = r_scan_en;
  assign scan_ck_enable = r_ck_en;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: FWFT input FIFO model, output capture, cycle-stamped monitor.
module tb_scan_chain_ctrl;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] length = '0;
  logic [7:0]  div = '0;
  logic        capture = 1'b0;
  logic        busy, done;
  logic [31:0] in_data;
  logic        in_empty;
  logic        in_rd_en;
  logic [31:0] out_data;
  logic        out_wr_en;
  logic        out_almost_full = 1'b0;
  logic [3:0]  scan_output = 4'h0;
  logic [3:0]  scan_input;
  logic        scan_enable, scan_ck_enable;

  scan_chain_ctrl #(.DATA_WIDTH(32), .NUM_CHAINS(4), .LEN_WIDTH(16), .DIV_WIDTH(8)) dut (
    .aclk(aclk), .areset(areset), .start(start), .abort(abort), .length(length), .div(div),
    .capture(capture), .busy(busy), .done(done), .in_data(in_data), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_data(out_data), .out_wr_en(out_wr_en),
    .out_almost_full(out_almost_full), .scan_output(scan_output), .scan_input(scan_input),
    .scan_enable(scan_enable), .scan_ck_enable(scan_ck_enable)
  );

  // clock / cycle counter
  always #5 aclk = ~aclk;
  int cyc = 0;
  always @(posedge aclk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // input FIFO model (first-word-fall-through)
  logic [31:0] in_q[$];
  logic        stall = 1'b0;
  always_comb begin
    in_empty = stall || (in_q.size() == 0);
    in_data  = (in_q.size() != 0) ? in_q[0] : 32'h0;
  end
  always @(posedge aclk) if (!areset && in_rd_en && !in_empty) void'(in_q.pop_front());

  // monitor
  int n_rd, n_wr, n_done, n_pulse, n_cap, n_stall_pulse, n_stall_se_low;
  int done_cyc, cap_cyc, start_cyc;
  int rd_cyc_q[$], wr_cyc_q[$], pulse_cyc_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  si_q[$];

  always @(negedge aclk) begin
    if (!areset) begin
      if (in_rd_en) begin n_rd++; rd_cyc_q.push_back(cyc); end
      if (out_wr_en) begin n_wr++; wr_cyc_q.push_back(cyc); wr_data_q.push_back(out_data); end
      if (done) begin n_done++; done_cyc = cyc; end
      if (scan_ck_enable) begin
        if (scan_enable) begin
          n_pulse++; pulse_cyc_q.push_back(cyc); si_q.push_back(scan_input);
        end else begin
          n_cap++; cap_cyc = cyc;
        end
        if (stall) n_stall_pulse++;
      end
      if (stall && busy && !scan_enable) n_stall_se_low++;
    end
  end

  // scoreboard
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] qd(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] pack_si(input int first);
    logic [31:0] w = '0;
    for (int k = 0; k < 8; k++)
      if (first + k < si_q.size()) w[k*4 +: 4] = si_q[first + k];
    return w;
  endfunction

  // driver tasks
  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_done = 0; n_pulse = 0; n_cap = 0;
    n_stall_pulse = 0; n_stall_se_low = 0; done_cyc = -1; cap_cyc = -1;
    rd_cyc_q.delete(); wr_cyc_q.delete(); pulse_cyc_q.delete();
    wr_data_q.delete(); si_q.delete();
  endtask

  task automatic do_start(input int len, input int d, input logic cap);
    @(posedge aclk); #1;
    length = 16'(len); div = 8'(d); capture = cap; start = 1'b1; start_cyc = cyc;
    @(posedge aclk); #1;
    start = 1'b0; capture = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(posedge aclk); #1; n++; end
    check({tag, "_idle"}, (n < budget), 1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic wait_pulses(input int want, input string tag);
    int n = 0;
    while (n_pulse < want && n < 200) begin @(negedge aclk); n++; end
    check({tag, "_pulses_seen"}, (n_pulse >= want), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, in_rd_en, out_wr_en, scan_enable, scan_ck_enable}, 0);
    check({tag, "_scan_input"}, scan_input, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  // L=8, D=0 single-word job with tails 4'hA
  task automatic run_basic(input string tag, input logic cap);
    clear_mon();
    scan_output = 4'hA;
    in_q.push_back(32'h76543210);
    do_start(8, 0, cap);
    wait_idle(100, tag);
    check({tag, "_n_rd"}, n_rd, 1);
    check({tag, "_n_pulse"}, n_pulse, 8);
    check({tag, "_pulse_span"}, qi(pulse_cyc_q, 7) - qi(pulse_cyc_q, 0), 7);
    check({tag, "_rd_to_pulse"}, qi(pulse_cyc_q, 0) - qi(rd_cyc_q, 0), 1);
    check({tag, "_scan_in_seq"}, pack_si(0), 32'h76543210);
    check({tag, "_n_wr"}, n_wr, 1);
    check({tag, "_wr_data"}, qd(wr_data_q, 0), 32'hAAAAAAAA);
    check({tag, "_pulse_to_wr"}, qi(wr_cyc_q, 0) - qi(pulse_cyc_q, 7), 1);
    check({tag, "_wr_to_done"}, done_cyc - qi(wr_cyc_q, 0), 1);
    check({tag, "_n_done"}, n_done, 1);
  endtask

  logic [31:0] t2_wr0, t2_wr1;

  initial begin
    clear_mon();
    // reset
    repeat (3) @(posedge aclk);
    #1;
    check_outputs_zero("reset");
    areset = 1'b0;

    // basic: start -> in_rd_en latency 1
    run_basic("basic", 1'b0);
    check("basic_start_to_rd", qi(rd_cyc_q, 0) - start_cyc, 1);

    // L=10, D=2: two words, second partial
    clear_mon();
    scan_output = 4'h5;
    in_q.push_back(32'hFEDCBA98);
    in_q.push_back(32'h13579BDF);
    do_start(10, 2, 1'b0);
    wait_idle(200, "l10");
    check("l10_n_rd", n_rd, 2);
    check("l10_n_pulse", n_pulse, 10);
    check("l10_rd_to_pulse", qi(pulse_cyc_q, 0) - qi(rd_cyc_q, 0), 3);
    check("l10_spacing_a", qi(pulse_cyc_q, 1) - qi(pulse_cyc_q, 0), 3);
    check("l10_spacing_b", qi(pulse_cyc_q, 9) - qi(pulse_cyc_q, 8), 3);
    check("l10_scan_in_w0", pack_si(0), 32'hFEDCBA98);
    check("l10_scan_in_w1", pack_si(8), 32'h000000DF);
    check("l10_n_wr", n_wr, 2);
    check("l10_wr0", qd(wr_data_q, 0), 32'h55555555);
    check("l10_wr1", qd(wr_data_q, 1), 32'h00000055);
    check("l10_n_done", n_done, 1);
    check("l10_fifo_drained", in_q.size(), 0);
    t2_wr0 = qd(wr_data_q, 0);
    t2_wr1 = qd(wr_data_q, 1);

    // same job with a 20-cycle input stall before the second word
    clear_mon();
    in_q.push_back(32'hFEDCBA98);
    in_q.push_back(32'h13579BDF);
    fork
      begin
        do_start(10, 2, 1'b0);
        wait_idle(300, "stall");
      end
      begin
        int k = 0;
        while (!out_wr_en && k < 100) begin @(negedge aclk); k++; end
        check("stall_first_wr_seen", (k < 100), 1);
        stall = 1'b1;
        repeat (20) @(posedge aclk);
        #1;
        stall = 1'b0;
      end
    join
    check("stall_no_pulses", n_stall_pulse, 0);
    check("stall_se_held", n_stall_se_low, 0);
    check("stall_rd_gap", qi(rd_cyc_q, 1) - qi(wr_cyc_q, 0), 21);
    check("stall_n_pulse", n_pulse, 10);
    check("stall_scan_in_w1", pack_si(8), 32'h000000DF);
    check("stall_wr0", qd(wr_data_q, 0), t2_wr0);
    check("stall_wr1", qd(wr_data_q, 1), t2_wr1);
    check("stall_n_done", n_done, 1);

    // output almost-full for 15 cycles at the first WRITE
    clear_mon();
    scan_output = 4'h3;
    in_q.push_back(32'h89ABCDEF);
    out_almost_full = 1'b1;
    do_start(8, 0, 1'b0);
    repeat (23) @(posedge aclk);
    #1;
    out_almost_full = 1'b0;
    wait_idle(100, "afull");
    check("afull_wr_cycle", qi(wr_cyc_q, 0) - start_cyc, 25);
    check("afull_n_wr", n_wr, 1);
    check("afull_wr_data", qd(wr_data_q, 0), 32'h33333333);
    check("afull_scan_in", pack_si(0), 32'h89ABCDEF);
    check("afull_wr_to_done", done_cyc - qi(wr_cyc_q, 0), 1);

    // zero length: no FIFO traffic, done two cycles after start
    clear_mon();
    in_q.push_back(32'h11111111);
    do_start(0, 0, 1'b0);
    wait_idle(20, "len0");
    check("len0_done_cycle", done_cyc - start_cyc, 2);
    check("len0_n_done", n_done, 1);
    check("len0_no_rd", n_rd, 0);
    check("len0_no_wr", n_wr, 0);
    check("len0_no_pulse", n_pulse, 0);
    check("len0_fifo_untouched", in_q.size(), 1);
    in_q.delete();

    // start while busy is ignored
    clear_mon();
    scan_output = 4'hA;
    in_q.push_back(32'h76543210);
    in_q.push_back(32'h0F0F0F0F);
    do_start(8, 3, 1'b0);
    repeat (5) @(posedge aclk);
    do_start(4, 0, 1'b0);
    wait_idle(200, "busy_start");
    check("busy_start_n_rd", n_rd, 1);
    check("busy_start_n_pulse", n_pulse, 8);
    check("busy_start_n_done", n_done, 1);
    check("busy_start_fifo_left", in_q.size(), 1);
    in_q.delete();

    // abort mid-shift
    clear_mon();
    in_q.push_back(32'h76543210);
    do_start(8, 3, 1'b0);
    wait_pulses(2, "abort");
    @(posedge aclk); #1;
    abort = 1'b1;
    @(posedge aclk); #1;
    abort = 1'b0;
    check_outputs_zero("abort");
    repeat (40) @(posedge aclk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_no_wr", n_wr, 0);
    check("abort_n_rd", n_rd, 1);
    in_q.delete();
    run_basic("after_abort", 1'b0);

    // synchronous reset mid-shift
    clear_mon();
    in_q.push_back(32'h76543210);
    do_start(8, 3, 1'b0);
    wait_pulses(3, "rst");
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    check_outputs_zero("midrst");
    areset = 1'b0;
    repeat (40) @(posedge aclk);
    #1;
    check("midrst_no_done", n_done, 0);
    check("midrst_no_wr", n_wr, 0);
    in_q.delete();
    run_basic("after_rst", 1'b0);

    // capture request
    run_basic("cap", 1'b1);
`ifdef SCAN_CAPTURE_EN
    check("cap_one_pulse", n_cap, 1);
    check("cap_pulse_cycle", cap_cyc - start_cyc, 1);
    check("cap_start_to_rd", qi(rd_cyc_q, 0) - start_cyc, 2);
`else
    check("cap_ignored", n_cap, 0);
    check("cap_start_to_rd", qi(rd_cyc_q, 0) - start_cyc, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
